// File: rtl/i2c_write_seq.sv
// i2c_write_seq: I2C write transaction sequencer for the codec configuration bus.
// Sends START, NBYTES data bytes (MSB first, top byte first), each followed by
// an ACK slot, then STOP. All bit timing comes from tickX16, where 16 ticks make
// one SCL period. The slave may stretch SCL at phase 7 of BIT, ACK and STOP.
// Optional feature macro: I2C_SEQ_ACK_CHECK_EN. When it is defined, a NACK
// sets ackErr and aborts straight to STOP. When it is not defined, the ACK
// sample is ignored and ackErr is tied low.
module i2c_write_seq #(
  parameter int NBYTES = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tickX16,
  input  logic                  start,
  input  logic [8*NBYTES-1:0]   data,
  output logic                  busy,
  output logic                  done,
  output logic                  ackErr,
  output logic                  sdatOut,
  output logic                  sclkOut,
  input  logic                  sdatFlt,
  input  logic                  sclkFlt
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    BIT   = 3'd2,
    ACK   = 3'd3,
    STOP  = 3'd4
  } stateT;

  localparam logic [2:0] LASTBYTE = 3'(NBYTES - 1);

  // Returns byte number idx of the latched word, counting from the top byte.
  function automatic logic [7:0] pickByte(input logic [8*NBYTES-1:0] w,
                                          input logic [2:0] idx);
    logic [8*NBYTES-1:0] t;
    t = w << {idx, 3'b000};
    return t[8*NBYTES-1 -: 8];
  endfunction

  stateT               stateR, stateN;
  logic [3:0]          phR, phN;
  logic [2:0]          bitR, bitN;
  logic [2:0]          byteR, byteN;
  logic [7:0]          shiftR, shiftN;
  logic [8*NBYTES-1:0] wordR, wordN;
  logic                busyN, doneN, sdaN, sclN;
  logic                stall, advance, accept, ackSample, ackAbort;

  // A stretch holds ph at 7 while SCL is released by us but still held low by the slave.
  assign stall     = ((stateR == BIT) || (stateR == ACK) || (stateR == STOP)) &&
                     (phR == 4'd7) && sclkOut && !sclkFlt;
  assign advance   = tickX16 && !stall;
  assign accept    = (stateR == IDLE) && start;
  assign ackSample = (stateR == ACK) && advance && (phR == 4'd11);

`ifdef I2C_SEQ_ACK_CHECK_EN
  assign ackAbort = ackErr;

  // NACK flag: cleared when a transaction is accepted, set when SDA reads high at ACK ph 11.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ackErr <= 1'b0;
    end else if (accept) begin
      ackErr <= 1'b0;
    end else if (ackSample && sdatFlt) begin
      ackErr <= 1'b1;
    end else begin
      ackErr <= ackErr;
    end
  end
`else
  logic unusedAckPath;
  assign ackAbort      = 1'b0;
  assign ackErr        = 1'b0;
  assign unusedAckPath = ackSample & sdatFlt;
`endif

  // Next-state logic: phase stepping, bit/byte counting and shift register control.
  always_comb begin
    stateN = stateR;
    phN    = phR;
    bitN   = bitR;
    byteN  = byteR;
    shiftN = shiftR;
    wordN  = wordR;
    busyN  = busy;
    doneN  = 1'b0;
    case (stateR)
      IDLE: begin
        phN = 4'd0;
        if (start) begin
          wordN  = data;
          busyN  = 1'b1;
          stateN = START;
        end else begin
          busyN  = 1'b0;
        end
      end
      START: begin
        if (advance) begin
          phN = phR + 4'd1;
          if (phR == 4'd15) begin
            stateN = BIT;
            bitN   = 3'd7;
            byteN  = 3'd0;
            shiftN = pickByte(wordR, 3'd0);
          end else begin
            stateN = START;
          end
        end else begin
          phN = phR;
        end
      end
      BIT: begin
        if (advance) begin
          phN = phR + 4'd1;
          if (phR == 4'd15) begin
            shiftN = {shiftR[6:0], 1'b0};
            if (bitR == 3'd0) begin
              stateN = ACK;
            end else begin
              bitN = bitR - 3'd1;
            end
          end else begin
            stateN = BIT;
          end
        end else begin
          phN = phR;
        end
      end
      ACK: begin
        if (advance) begin
          phN = phR + 4'd1;
          if (phR == 4'd15) begin
            if (ackAbort || (byteR == LASTBYTE)) begin
              stateN = STOP;
            end else begin
              stateN = BIT;
              bitN   = 3'd7;
              byteN  = byteR + 3'd1;
              shiftN = pickByte(wordR, byteR + 3'd1);
            end
          end else begin
            stateN = ACK;
          end
        end else begin
          phN = phR;
        end
      end
      STOP: begin
        if (advance) begin
          phN = phR + 4'd1;
          if (phR == 4'd15) begin
            stateN = IDLE;
            busyN  = 1'b0;
            doneN  = 1'b1;
          end else begin
            stateN = STOP;
          end
        end else begin
          phN = phR;
        end
      end
      default: begin
        stateN = IDLE;
        phN    = 4'd0;
        busyN  = 1'b0;
      end
    endcase
  end

  // Line decode from the upcoming state/phase so the registered lines track ph exactly.
  always_comb begin
    sdaN = 1'b1;
    sclN = 1'b1;
    case (stateN)
      IDLE: begin
        sdaN = 1'b1;
        sclN = 1'b1;
      end
      START: begin
        sclN = 1'b1;
        if (phN < 4'd8) begin
          sdaN = 1'b1;
        end else begin
          sdaN = 1'b0;
        end
      end
      BIT: begin
        sclN = (phN >= 4'd4) && (phN <= 4'd11);
        if (phN == 4'd0) begin
          sdaN = shiftN[7];
        end else begin
          sdaN = sdatOut;
        end
      end
      ACK: begin
        sclN = (phN >= 4'd4) && (phN <= 4'd11);
        sdaN = 1'b1;
      end
      STOP: begin
        if (phN < 4'd4) begin
          sdaN = 1'b0;
          sclN = 1'b0;
        end else if (phN < 4'd12) begin
          sdaN = 1'b0;
          sclN = 1'b1;
        end else begin
          sdaN = 1'b1;
          sclN = 1'b1;
        end
      end
      default: begin
        sdaN = 1'b1;
        sclN = 1'b1;
      end
    endcase
  end

  // State and output registers; reset releases both bus lines at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateR  <= IDLE;
      phR     <= 4'd0;
      bitR    <= 3'd7;
      byteR   <= 3'd0;
      shiftR  <= 8'h00;
      wordR   <= {(8*NBYTES){1'b0}};
      busy    <= 1'b0;
      done    <= 1'b0;
      sdatOut <= 1'b1;
      sclkOut <= 1'b1;
    end else begin
      stateR  <= stateN;
      phR     <= phN;
      bitR    <= bitN;
      byteR   <= byteN;
      shiftR  <= shiftN;
      wordR   <= wordN;
      busy    <= busyN;
      done    <= doneN;
      sdatOut <= sdaN;
      sclkOut <= sclN;
    end
  end

endmodule

// File: doc/i2c_write_seq.md
# i2c_write_seq

Transaction sequencer for the audio codec configuration bus. It performs a complete I2C write: START, NBYTES data bytes each followed by an ACK slot, then STOP. It drives the open-drain line-control inputs (`sdatOut`/`sclkOut`) of the i2c line block and reads back that block's filtered `sdatFlt`/`sclkFlt`. Bit timing is derived from the shared `tickX16` reference (16 ticks per SCL period). It supports slave clock stretching and ACK checking.

## Interface
Parameters:
- `NBYTES`, default 3: bytes per transaction, legal range 1..4. The default of 3 covers device address, register high byte and register low byte.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset (asserted at 0).
- `tickX16`  in  1  one-`clk` strobe at 16x the SCL rate.
- `start`  in  1  request a transaction; sampled only in IDLE.
- `data`  in  8*NBYTES  payload; latched when `start` is accepted; top byte sent first, MSB first.
- `busy`  out  1  high from the accepting cycle until `done`.
- `done`  out  1  one-`clk` pulse when the transaction ends (normal or aborted).
- `ackErr`  out  1  NACK seen in the last transaction; held until the next accepted `start`.
- `sdatOut`  out  1  SDA control: 1 releases the line, 0 pulls it low.
- `sclkOut`  out  1  SCL control: 1 releases the line, 0 pulls it low.
- `sdatFlt`  in  1  filtered SDA from the line block.
- `sclkFlt`  in  1  filtered SCL from the line block.

## Operation
- FSM states: IDLE, START, BIT, ACK, STOP.
- A 4-bit phase counter `ph` (0..15) advances on each `tickX16`. Each state lasts one full `ph` cycle unless stretched.
- IDLE:
  - outputs: `sdatOut`=1, `sclkOut`=1, `busy`=0.
  - `start`=1 latches `data` into a shift register, clears `ackErr`, resets `ph`=0, goes to START.
- START:
  - ph 0..7: `sdatOut`=1, `sclkOut`=1.
  - ph 8..15: `sdatOut`=0, `sclkOut`=1.
  - Then BIT, with bit count 7 and byte count 0.
- BIT:
  - `sdatOut` = current MSB, updated at ph 0 only.
  - `sclkOut`=0 for ph 0..3 and 12..15; `sclkOut`=1 for ph 4..11.
  - After bit 0 of a byte, go to ACK.
- ACK:
  - Same SCL pattern as BIT, with `sdatOut`=1 (released).
  - SDA is sampled at ph 11.
  - If another byte remains, go to BIT; otherwise go to STOP.
- STOP:
  - ph 0..3: `sdatOut`=0, `sclkOut`=0.
  - ph 4..11: `sdatOut`=0, `sclkOut`=1.
  - ph 12..15: `sdatOut`=1, `sclkOut`=1.
  - Then `done` pulses and the FSM returns to IDLE.
- Clock stretching:
  - Applies in BIT, ACK and STOP.
  - At ph 7, `ph` holds while `sclkOut`=1 and `sclkFlt`=0, and resumes on the first `tickX16` after `sclkFlt`=1.
  - Stretch duration is unbounded.
- `start` while `busy` is ignored; it is not queued.
- Shift register: shifts left by 1 at the end of each BIT and refills from the latched word at the start of each byte.

## Timing
- Reset values of all outputs: `sdatOut`=1, `sclkOut`=1, `busy`=0, `done`=0, `ackErr`=0; FSM in IDLE, `ph`=0.
- Asserting `reset` mid-transaction releases both lines immediately (asynchronous). No STOP is generated.
- `busy` rises on the `clk` edge after `start` is sampled high in IDLE.
- Unstretched transaction length: 16·(2 + 9·NBYTES) ticks, i.e. 464 ticks for NBYTES=3.
- `done` is asserted on the `clk` after the final STOP tick (ph 15). `busy` falls on that same edge.
- A new `start` is accepted on the cycle after `done`.
- ph 7 and ph 11 are chosen to cover the line-block latency: 2-flop synchronizer plus up to 2 ticks of majority filtering.
- A `tickX16` arriving in the same cycle as `start` is not counted; ph 0 begins on the next tick.

## Configuration
- `I2C_SEQ_ACK_CHECK_EN` defined:
  - SDA=1 sampled at ACK ph 11 sets `ackErr`=1.
  - The FSM then goes directly to STOP, and the remaining bytes are skipped.
- Macro undefined:
  - The ACK sample is ignored and all bytes are always sent.
  - `ackErr` is tied to 0.

## Test plan
- Nominal write: NBYTES=3, `data`=0x34_1E_00, slave ACKs every byte. Required response:
  - SDA bits on the SCL rising edges are 0011_0100, 0001_1110, 0000_0000, with SDA released in each ACK slot.
  - `done` arrives exactly 464 ticks after START; `ackErr`=0.
- NACK on the address byte, macro defined. Required response:
  - STOP begins immediately after the first ACK slot.
  - `done` arrives 16·11=176 ticks after START; `ackErr`=1.
- Same NACK, macro undefined. Required response: all 3 bytes are sent, 464 ticks total, `ackErr`=0.
- Slave holds SCL low for 40 ticks during bit 3 of byte 1. Required response:
  - `ph` holds at 7 for the stretch duration.
  - Total length is 464 + 40 ± 3 ticks; no SDA change occurs while SCL is high.
- `reset` asserted at ph 9 of byte 2. Required response:
  - `sdatOut`=`sclkOut`=1 and `busy`=0 in the same cycle; no `done` pulse.
  - After release, a new `start` runs normally.
- `start` pulsed while `busy`, then again 1 cycle after `done`. Required response: the first is ignored; the second is accepted and `busy`=1 on the next `clk`.
